// File: rtl/fpm_arb_pkg.sv
// Shared types and defaults for the FP multiplier arbiter slice.
package fpm_arb_pkg;

    localparam int DATA_W_DEFAULT = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at ptr and wraps,
// granting the first asserted request as a one-hot vector.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt
);

    localparam int IDX_W = $clog2(N);

    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] idx;
    logic             found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            // One extra bit so ptr+i cannot wrap before the modulo-N fold.
            sum = {1'b0, ptr} + (IDX_W+1)'(i);
            if (sum >= (IDX_W+1)'(N)) begin
                sum = sum - (IDX_W+1)'(N);
            end
            idx = sum[IDX_W-1:0];
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fp_mul_arbiter.sv
// Round-robin front end that time-shares one external FP multiplier among
// NUM_REQ requesters, with a single operation in flight at a time.
module fp_mul_arbiter
    import fpm_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int MUL_LATENCY = 4,
    parameter int DATA_W      = DATA_W_DEFAULT
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      rsp_overflow,
    output logic                      busy,
    output logic [7:0]                ovf_count,
    output logic                      mul_enable,
    output logic [DATA_W-1:0]         mul_in1,
    output logic [DATA_W-1:0]         mul_in2,
    input  logic [DATA_W-1:0]         mul_out,
    input  logic                      mul_overflow
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LATENCY - 1);

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    last_grant_q, last_grant_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                mul_enable_q, mul_enable_d;
    logic [DATA_W-1:0]   mul_in1_q, mul_in1_d;
    logic [DATA_W-1:0]   mul_in2_q, mul_in2_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic                rsp_overflow_q, rsp_overflow_d;
    logic [7:0]          ovf_count_q, ovf_count_d;

    logic [IDX_W-1:0]    rr_ptr;
    logic [IDX_W-1:0]    win_idx;
    logic [NUM_REQ-1:0]  gnt;
    logic [DATA_W-1:0]   win_a, win_b;
    logic                accept;

    assign rr_ptr = (last_grant_q == LAST_IDX) ? '0 : last_grant_q + 1'b1;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req (req_valid),
        .ptr (rr_ptr),
        .gnt (gnt)
    );

    always_comb begin
        win_idx = '0;
        win_a   = '0;
        win_b   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                win_idx = IDX_W'(i);
                win_a   = req_a[i*DATA_W +: DATA_W];
                win_b   = req_b[i*DATA_W +: DATA_W];
            end
        end
    end

    // Ready is also masked by reset so nothing looks accepted while held in reset.
    assign req_ready = (state_q == IDLE && reset) ? gnt : '0;
    assign accept    = |(req_valid & req_ready);

    always_comb begin
        state_d        = state_q;
        last_grant_d   = last_grant_q;
        cnt_d          = cnt_q;
        mul_enable_d   = mul_enable_q;
        mul_in1_d      = mul_in1_q;
        mul_in2_d      = mul_in2_q;
        rsp_data_d     = rsp_data_q;
        rsp_overflow_d = rsp_overflow_q;
        ovf_count_d    = ovf_count_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    mul_in1_d    = win_a;
                    mul_in2_d    = win_b;
                    last_grant_d = win_idx;
                    state_d      = SETUP;
                end
            end
            SETUP: begin
                mul_enable_d = 1'b1;
                cnt_d        = CNT_LOAD;
                state_d      = WAIT;
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    rsp_data_d     = mul_out;
                    rsp_overflow_d = mul_overflow;
                    mul_enable_d   = 1'b0;
                    state_d        = RESP;
                    if (mul_overflow && ovf_count_q != 8'hFF) begin
                        ovf_count_d = ovf_count_q + 8'd1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            last_grant_q   <= LAST_IDX;
            cnt_q          <= '0;
            mul_enable_q   <= 1'b0;
            mul_in1_q      <= '0;
            mul_in2_q      <= '0;
            rsp_data_q     <= '0;
            rsp_overflow_q <= 1'b0;
            ovf_count_q    <= '0;
        end else begin
            state_q        <= state_d;
            last_grant_q   <= last_grant_d;
            cnt_q          <= cnt_d;
            mul_enable_q   <= mul_enable_d;
            mul_in1_q      <= mul_in1_d;
            mul_in2_q      <= mul_in2_d;
            rsp_data_q     <= rsp_data_d;
            rsp_overflow_q <= rsp_overflow_d;
            ovf_count_q    <= ovf_count_d;
        end
    end

    // last_grant_q doubles as the id of the operation in flight.
    always_comb begin
        rsp_valid = '0;
        if (state_q == RESP) begin
            rsp_valid[last_grant_q] = 1'b1;
        end
    end

    assign busy         = (state_q != IDLE);
    assign mul_enable   = mul_enable_q;
    assign mul_in1      = mul_in1_q;
    assign mul_in2      = mul_in2_q;
    assign rsp_data     = rsp_data_q;
    assign rsp_overflow = rsp_overflow_q;
    assign ovf_count    = ovf_count_q;

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Directed bench for fp_mul_arbiter with a stub multiplier that only yields a
// product once mul_enable has been held for the full latency.
module tb_fp_mul_arbiter;

    localparam int NREQ    = 4;
    localparam int MUL_LAT = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req_valid, req_ready, rsp_valid;
    logic [NREQ*32-1:0] req_a, req_b;
    logic [31:0]       rsp_data, mul_in1, mul_in2, mul_out;
    logic              rsp_overflow, busy, mul_enable, mul_overflow;
    logic [7:0]        ovf_count;

    int n_checks;
    int n_fail;
    int exp_ovf_cnt;
    int en_cnt;

    typedef struct {
        logic [3:0]  mask;
        int unsigned win;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_data;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs [5];

    fp_mul_arbiter #(
        .NUM_REQ     (NREQ),
        .MUL_LATENCY (MUL_LAT),
        .DATA_W      (32)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a        (req_a),
        .req_b        (req_b),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .rsp_overflow (rsp_overflow),
        .busy         (busy),
        .ovf_count    (ovf_count),
        .mul_enable   (mul_enable),
        .mul_in1      (mul_in1),
        .mul_in2      (mul_in2),
        .mul_out      (mul_out),
        .mul_overflow (mul_overflow)
    );

    always #5 clk = ~clk;

    // Hand-computed products for the operand pairs used below; {overflow, product}.
    function automatic logic [32:0] fmul(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            64'h40aa6666_40aa6666: return {1'b0, 32'h41e2d850};
            64'h3f800000_40480000: return {1'b0, 32'h40480000};
            64'h7f000000_7f000000: return {1'b1, 32'h7f800000};
            64'hc0080000_c0680000: return {1'b0, 32'h40f68000};
            default:               return {1'b0, 32'h00000000};
        endcase
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)          en_cnt <= 0;
        else if (mul_enable) en_cnt <= en_cnt + 1;
        else                 en_cnt <= 0;
    end

    always_comb begin
        if (mul_enable && en_cnt == MUL_LAT - 1) begin
            {mul_overflow, mul_out} = fmul(mul_in1, mul_in2);
        end else begin
            mul_out      = 32'hdeadbeef;
            mul_overflow = 1'b1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic int oh2idx(input logic [3:0] v);
        int r;
        r = -1;
        for (int i = 0; i < 4; i++) if (v[i]) r = i;
        return r;
    endfunction

    // Caller must be in the low phase with the DUT idle.
    task automatic do_op(input logic [3:0] mask, input int unsigned win,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_data, input logic exp_ovf);
        int k, lat, en;
        bit stable, ready_seen;
        req_valid = mask;
        for (int i = 0; i < NREQ; i++) begin
            if (mask[i]) begin
                req_a[i*32 +: 32] = a;
                req_b[i*32 +: 32] = b;
            end
        end
        #1;
        k = 0;
        while (req_ready == '0 && k < 20) begin
            @(negedge clk); #1; k++;
        end
        check("grant", 32'(req_ready), 32'(1) << win);
        if (req_ready == '0) begin
            req_valid = '0;
            return;
        end
        @(negedge clk);
        req_valid[win] = 1'b0;
        req_a[win*32 +: 32] = ~a;
        req_b[win*32 +: 32] = ~b;
        #1;
        check("setup_busy", 32'(busy), 32'(1));
        check("setup_in1", mul_in1, a);
        check("setup_in2", mul_in2, b);
        check("setup_enable", 32'(mul_enable), 32'(0));
        lat = 0; en = 0; stable = 1'b1; ready_seen = 1'b0;
        while (rsp_valid == '0 && lat < 20) begin
            @(negedge clk); #1; lat++;
            if (mul_enable) en++;
            if (req_ready != '0) ready_seen = 1'b1;
            if (rsp_valid == '0 && (mul_in1 !== a || mul_in2 !== b)) stable = 1'b0;
        end
        req_valid = '0;
        if (exp_ovf && exp_ovf_cnt != 255) exp_ovf_cnt++;
        check("latency", 32'(lat), 32'(MUL_LAT + 1));
        check("enable_cycles", 32'(en), 32'(MUL_LAT));
        check("operands_stable", 32'(stable), 32'(1));
        check("ready_while_busy", 32'(ready_seen), 32'(0));
        check("rsp_valid", 32'(rsp_valid), 32'(1) << win);
        check("rsp_data", rsp_data, exp_data);
        check("rsp_overflow", 32'(rsp_overflow), 32'(exp_ovf));
        check("ovf_count", 32'(ovf_count), 32'(exp_ovf_cnt));
        check("resp_enable", 32'(mul_enable), 32'(0));
        @(negedge clk); #1;
        check("rsp_strobe_len", 32'(rsp_valid), 32'(0));
        check("idle_busy", 32'(busy), 32'(0));
        check("rsp_hold", rsp_data, exp_data);
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        exp_ovf_cnt = 0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    int gidx [4];
    int gtime [4];
    int ng, nr, cyc, k;
    logic [3:0] drop;
    bit seen;
    int exp_fair [4];

    initial begin
        n_checks = 0; n_fail = 0; exp_ovf_cnt = 0;
        reset = 1'b0; req_valid = '1; req_a = '0; req_b = '0;

        vecs[0] = '{4'b0001, 0, 32'h40aa6666, 32'h40aa6666, 32'h41e2d850, 1'b0};
        vecs[1] = '{4'b0100, 2, 32'h7f000000, 32'h7f000000, 32'h7f800000, 1'b1};
        vecs[2] = '{4'b0010, 1, 32'hc0080000, 32'hc0680000, 32'h40f68000, 1'b0};
        vecs[3] = '{4'b1000, 3, 32'h3f800000, 32'h40480000, 32'h40480000, 1'b0};
        vecs[4] = '{4'b1010, 1, 32'h3f800000, 32'h40480000, 32'h40480000, 1'b0};
        exp_fair = '{1, 3, 1, 3};

        #1;
        check("rst_ready", 32'(req_ready), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_enable", 32'(mul_enable), 32'(0));
        check("rst_in1", mul_in1, 32'(0));
        check("rst_in2", mul_in2, 32'(0));
        check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
        check("rst_rsp_data", rsp_data, 32'(0));
        check("rst_rsp_ovf", 32'(rsp_overflow), 32'(0));
        check("rst_ovf_count", 32'(ovf_count), 32'(0));
        repeat (2) @(negedge clk);
        reset = 1'b1;
        req_valid = '0;
        #1;

        for (int i = 0; i < 5; i++) begin
            do_op(vecs[i].mask, vecs[i].win, vecs[i].a, vecs[i].b,
                  vecs[i].exp_data, vecs[i].exp_ovf);
        end

        // Contention straight out of reset: all four valid, each drops after acceptance.
        @(negedge clk);
        apply_reset();
        req_valid = '1;
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*32 +: 32] = 32'h3f800000;
            req_b[i*32 +: 32] = 32'h40480000;
        end
        #1;
        ng = 0; nr = 0; cyc = 0;
        while ((ng < 4 || nr < 4) && cyc < 100) begin
            drop = req_ready;
            if (req_ready != '0 && ng < 4) begin
                gidx[ng] = oh2idx(req_ready); gtime[ng] = cyc; ng++;
            end
            if (rsp_valid != '0 && nr < ng) begin
                check("cont_rsp_valid", 32'(rsp_valid), 32'(1) << gidx[nr]);
                check("cont_rsp_data", rsp_data, 32'h40480000);
                nr++;
            end
            @(negedge clk);
            req_valid = req_valid & ~drop;
            #1; cyc++;
        end
        check("cont_grants", 32'(ng), 32'(4));
        check("cont_rsps", 32'(nr), 32'(4));
        for (int i = 0; i < ng; i++) begin
            check("cont_order", 32'(gidx[i]), 32'(i));
            if (i > 0) check("cont_interval", 32'(gtime[i] - gtime[i-1]), 32'(MUL_LAT + 3));
        end

        // Fairness: requesters 1 and 3 held valid throughout.
        req_valid = 4'b1010;
        #1;
        ng = 0; nr = 0; cyc = 0;
        while ((ng < 4 || nr < 4) && cyc < 100) begin
            if (req_ready != '0 && ng < 4) begin
                gidx[ng] = oh2idx(req_ready); ng++;
            end
            if (rsp_valid != '0 && nr < ng) begin
                check("fair_rsp_valid", 32'(rsp_valid), 32'(1) << gidx[nr]);
                nr++;
            end
            @(negedge clk);
            if (ng == 4) req_valid = '0;
            #1; cyc++;
        end
        check("fair_grants", 32'(ng), 32'(4));
        for (int i = 0; i < ng; i++) begin
            check("fair_order", 32'(gidx[i]), 32'(exp_fair[i]));
            if (i > 0 && gidx[i] == gidx[i-1]) check("fair_repeat", 32'(gidx[i]), 32'(-1));
        end

        // Overflow counter saturation.
        for (int i = 0; i < 256; i++) begin
            do_op(4'b0001, 0, 32'h7f000000, 32'h7f000000, 32'h7f800000, 1'b1);
        end
        check("ovf_saturated", 32'(ovf_count), 32'(255));

        // Reset asserted in the second WAIT cycle of requester 2's operation.
        req_valid = 4'b0100;
        req_a[64 +: 32] = 32'hc0080000;
        req_b[64 +: 32] = 32'hc0680000;
        #1;
        k = 0;
        while (req_ready == '0 && k < 20) begin
            @(negedge clk); #1; k++;
        end
        check("mw_grant", 32'(req_ready), 32'(4'b0100));
        @(negedge clk); req_valid = '0; #1;
        @(negedge clk); #1;
        @(negedge clk); #1;
        check("mw_enable_before", 32'(mul_enable), 32'(1));
        req_valid = 4'b0101;
        req_a[0 +: 32] = 32'hc0080000;
        req_b[0 +: 32] = 32'hc0680000;
        reset = 1'b0;
        exp_ovf_cnt = 0;
        #1;
        check("mw_enable_after", 32'(mul_enable), 32'(0));
        check("mw_busy", 32'(busy), 32'(0));
        check("mw_ready", 32'(req_ready), 32'(0));
        check("mw_in1", mul_in1, 32'(0));
        check("mw_ovf_count", 32'(ovf_count), 32'(0));
        seen = (rsp_valid != '0);
        repeat (3) begin
            @(negedge clk);
            if (rsp_valid != '0) seen = 1'b1;
        end
        check("mw_no_rsp", 32'(seen), 32'(0));
        reset = 1'b1;
        do_op(4'b0101, 0, 32'hc0080000, 32'hc0680000, 32'h40f68000, 1'b0);
        do_op(4'b0100, 2, 32'hc0080000, 32'hc0680000, 32'h40f68000, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/fp_mul_arbiter.md
FP_MUL_ARBITER -- requirements
Module: fp_mul_arbiter

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-002 Parameter NUM_REQ, default 4, SHALL set the number of requesters (2..8).
REQ-003 Parameter MUL_LATENCY, default 4, SHALL set the cycles the multiplier needs with mul_enable held high.
REQ-004 Parameter DATA_W, default 32, SHALL set the IEEE-754 single-precision word width.
REQ-005 Ports SHALL be:
  clk  in  1  clock, rising edge
  reset  in  1  async reset, 0 = reset asserted
  req_valid  in  NUM_REQ  per-requester operation request
  req_ready  out  NUM_REQ  per-requester accept, one-hot or zero
  req_a  in  NUM_REQ*DATA_W  operand A, requester i at slice i
  req_b  in  NUM_REQ*DATA_W  operand B, requester i at slice i
  rsp_valid  out  NUM_REQ  one-hot, one-cycle result strobe
  rsp_data  out  DATA_W  product, valid with rsp_valid
  rsp_overflow  out  1  multiplier overflow, valid with rsp_valid
  busy  out  1  high when state is not IDLE
  ovf_count  out  8  saturating count of overflowed operations
  mul_enable  out  1  enable to shared multiplier
  mul_in1, mul_in2  out  DATA_W  registered operands to multiplier
  mul_out  in  DATA_W  multiplier result
  mul_overflow  in  1  multiplier overflow flag

Function
REQ-006 The FSM SHALL have states IDLE, SETUP, WAIT, RESP.
REQ-007 In IDLE, req_ready SHALL be asserted only for the round-robin winner among asserted req_valid; all zero otherwise and in every other state.
REQ-008 Round-robin priority SHALL start at (last_grant+1) mod NUM_REQ; last_grant updates only on acceptance.
REQ-009 On acceptance (req_valid & req_ready), the block SHALL latch the winner's operands into mul_in1/mul_in2, record the grant id, and go to SETUP.
REQ-010 SETUP SHALL last one cycle with mul_enable=0, then enter WAIT.
REQ-011 In WAIT, mul_enable SHALL be 1 for exactly MUL_LATENCY cycles, counted by a down-counter loaded with MUL_LATENCY-1.
REQ-012 On the edge ending the last WAIT cycle, rsp_data and rsp_overflow SHALL capture mul_out and mul_overflow; mul_enable SHALL drop to 0; the state SHALL become RESP.
REQ-013 In RESP, rsp_valid SHALL be high for one cycle on the granted requester's bit only; the next state SHALL be IDLE.
REQ-014 Result latency SHALL be MUL_LATENCY+1 cycles from acceptance edge to rsp_valid; minimum issue interval SHALL be MUL_LATENCY+3 cycles.
REQ-015 Responses SHALL have no backpressure; rsp_data/rsp_overflow SHALL hold their value until the next capture.
REQ-016 A requester dropping req_valid before acceptance SHALL lose nothing; operand changes after acceptance SHALL not affect the in-flight operation.
REQ-017 ovf_count SHALL increment on each capture with mul_overflow=1 and saturate at 255.
REQ-018 mul_in1/mul_in2 SHALL stay stable from SETUP through the capture edge.

Reset
REQ-019 reset=0 SHALL asynchronously force state IDLE, last_grant NUM_REQ-1, counter 0, mul_enable 0, mul_in1/mul_in2 0, rsp_valid 0, rsp_data 0, rsp_overflow 0, ovf_count 0, req_ready 0.
REQ-020 Reset during SETUP/WAIT/RESP SHALL discard the in-flight operation with no rsp_valid pulse.

Structure
REQ-021 A shared package fpm_arb_pkg SHALL hold the state enum type and the DATA_W default.
REQ-022 Round-robin selection SHALL be one sub-module, rr_arbiter (req vector and pointer in, one-hot grant out, combinational).

Verification
REQ-023 Single request: requester 0, a=0x40aa6666, b=0x40aa6666 -> rsp_valid=0001 exactly 5 cycles after acceptance, rsp_data=0x41e2d850, rsp_overflow=0.
REQ-024 Contention after reset: all four req_valid high, requester i operands a=0x3f800000, b=0x40480000 -> grants in order 0,1,2,3, each rsp_data=0x40480000, accepts 7 cycles apart.
REQ-025 Fairness: requesters 1 and 3 held valid continuously -> grants alternate 1,3,1,3; neither granted twice consecutively.
REQ-026 Overflow: a=0x7f000000, b=0x7f000000 -> rsp_overflow=1, ovf_count 0->1; 256 such operations -> ovf_count holds 255.
REQ-027 Reset mid-WAIT: requester 2 accepted with a=0xc0080000, b=0xc0680000, reset pulsed low in 2nd WAIT cycle -> no rsp_valid, mul_enable=0 immediately, next request yields 0x40f68000 with requester 0 winning first.
